// File: rtl/echo_delay_gen2.sv
// Single-tap echo with runtime delay, Q1.(GAIN_W-1) gain, feed-forward or feedback mode.
// Two-stage pipeline around a synchronous delay-line RAM; history count masks stale RAM after reset.
module echo_delay_gen2 #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 14,
  parameter int GAIN_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [DEPTH_LOG2-1:0]    delay_time,
  input  logic signed [GAIN_W-1:0] alpha,
  input  logic                     mode,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     sat
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DATA_W + GAIN_W;
  localparam logic [DEPTH_LOG2:0]  HIST_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic signed [PW-1:0] ROUND     = PW'(2 ** (GAIN_W - 2));
  localparam logic signed [PW-1:0] SAT_MAX   = PW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN   = PW'(-(2 ** (DATA_W - 1)));

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0]    wp, rd_addr, s1_wp, s1_d;
  logic [DEPTH_LOG2:0]      hist, s1_hist;
  logic                     s1_valid, s1_mode;
  logic signed [DATA_W-1:0] s1_x, rd_data, delayed, y, wr_data;
  logic signed [GAIN_W-1:0] s1_alpha;
  logic signed [PW-1:0]     prod, scaled, sum;
  logic                     clip;

  assign rd_addr = wp - delay_time;

  // Stage 1: capture the sample and its controls, advance the write pointer and history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      wp       <= '0;
      hist     <= '0;
      s1_x     <= '0;
      s1_d     <= '0;
      s1_alpha <= '0;
      s1_mode  <= 1'b0;
      s1_wp    <= '0;
      s1_hist  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x     <= in_data;
        s1_d     <= delay_time;
        s1_alpha <= alpha;
        s1_mode  <= mode;
        s1_wp    <= wp;
        s1_hist  <= hist;
        wp       <= wp + DEPTH_LOG2'(1);
        if (hist != HIST_FULL) hist <= hist + (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

  always_comb begin
    delayed = '0;
    if (s1_d != '0 && s1_hist >= {1'b0, s1_d}) delayed = rd_data;
    prod   = PW'(s1_alpha) * PW'(delayed);
    scaled = (prod + ROUND) >>> (GAIN_W - 1);
    sum    = scaled + PW'(s1_x);
    clip   = (sum > SAT_MAX) || (sum < SAT_MIN);
    if (sum > SAT_MAX)      y = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sum < SAT_MIN) y = {1'b1, {(DATA_W-1){1'b0}}};
    else                    y = sum[DATA_W-1:0];
    wr_data = s1_mode ? y : s1_x;
  end

  // Single write port at stage 2; a same-cycle read of the address being written gets the new data
  always_ff @(posedge clk) begin
    if (s1_valid) mem[s1_wp] <= wr_data;
    if (in_valid) rd_data <= (s1_valid && rd_addr == s1_wp) ? wr_data : mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= y;
        sat      <= clip;
      end else begin
        sat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_echo_delay_gen2.sv
// Directed bench for echo_delay_gen2: default-size instance plus a 16-entry instance for wrap tests.
module tb_echo_delay_gen2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0, in_valid_s = 1'b0;
  logic signed [15:0] in_data = '0, in_data_s = '0;
  logic [13:0]        delay_time = '0;
  logic [3:0]         delay_s = '0;
  logic signed [15:0] alpha = '0, alpha_s = '0;
  logic               mode = 1'b0, mode_s = 1'b0;
  logic               out_valid, out_valid_s, sat, sat_s;
  logic signed [15:0] out_data, out_data_s;

  int errors = 0, checks = 0, cycle = 0, last_acc = 0, first_acc = 0;
  int sat_idle_err = 0, hold_err = 0, last_data = 0;
  int out_q[$], sat_q[$], cyc_q[$], out_s_q[$], exp_q[$], exp_sat_q[$];

  echo_delay_gen2 #(.DATA_W(16), .DEPTH_LOG2(14), .GAIN_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .delay_time(delay_time), .alpha(alpha), .mode(mode),
    .out_valid(out_valid), .out_data(out_data), .sat(sat)
  );

  echo_delay_gen2 #(.DATA_W(16), .DEPTH_LOG2(4), .GAIN_W(16)) u_dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_data(in_data_s),
    .delay_time(delay_s), .alpha(alpha_s), .mode(mode_s),
    .out_valid(out_valid_s), .out_data(out_data_s), .sat(sat_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Collect outputs on the falling edge, and watch idle-cycle behaviour of sat and out_data
  always @(negedge clk) begin
    if (out_valid) begin
      out_q.push_back(int'(out_data));
      sat_q.push_back(int'(sat));
      cyc_q.push_back(cycle);
    end else if (sat) begin
      sat_idle_err++;
    end
    if (rst) last_data = 0;
    else if (out_valid) last_data = int'(out_data);
    else if (int'(out_data) != last_data) hold_err++;
    if (out_valid_s) out_s_q.push_back(int'(out_data_s));
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit to_small, input bit valid, input int data);
    if (to_small) begin
      in_valid_s = valid;
      in_data_s  = data[15:0];
      in_valid   = 1'b0;
    end else begin
      in_valid   = valid;
      in_data    = data[15:0];
      in_valid_s = 1'b0;
    end
    if (valid) last_acc = cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    repeat (4) applyStimulus(1'b0, 1'b0, 0);
  endtask

  task automatic doReset();
    in_valid   = 1'b0;
    in_valid_s = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_q.delete();
    sat_q.delete();
    cyc_q.delete();
    out_s_q.delete();
    exp_q.delete();
    exp_sat_q.delete();
  endtask

  task automatic checkRun(input string name);
    checkOutput({name, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < out_q.size()) begin
        checkOutput($sformatf("%s_data%0d", name, i), out_q[i], exp_q[i]);
        checkOutput($sformatf("%s_sat%0d", name, i), sat_q[i], exp_sat_q[i]);
      end
    end
  endtask

  task automatic decayRun(input string name);
    applyStimulus(1'b0, 1'b1, 1000);
    repeat (19) applyStimulus(1'b0, 1'b1, 0);
    flush();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(i == 0 ? 1000 : i == 4 ? 500 : i == 8 ? 250 : i == 12 ? 125 : i == 16 ? 63 : 0);
      exp_sat_q.push_back(0);
    end
    checkRun(name);
  endtask

  initial begin
    int v;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_sat", int'(sat), 0);
    doReset();

    $display("[TB] feed-forward impulse");
    mode = 1'b0; delay_time = 14'd4; alpha = 16'sh4000;
    applyStimulus(1'b0, 1'b1, 1000);
    first_acc = last_acc;
    repeat (15) applyStimulus(1'b0, 1'b1, 0);
    flush();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(i == 0 ? 1000 : i == 4 ? 500 : 0);
      exp_sat_q.push_back(0);
    end
    checkRun("ff");
    if (cyc_q.size() > 0) checkOutput("ff_latency", cyc_q[0] - first_acc, 2);

    $display("[TB] feedback decay");
    doReset();
    mode = 1'b1; delay_time = 14'd4; alpha = 16'sh4000;
    decayRun("fb");

    $display("[TB] feedback with D=1 forwarding");
    doReset();
    mode = 1'b1; delay_time = 14'd1; alpha = 16'sh4000;
    applyStimulus(1'b0, 1'b1, 1000);
    repeat (7) applyStimulus(1'b0, 1'b1, 0);
    flush();
    exp_q = '{1000, 500, 250, 125, 63, 32, 16, 8};
    exp_sat_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    checkRun("fwd");

    $display("[TB] saturation");
    doReset();
    mode = 1'b0; delay_time = 14'd1; alpha = 16'sh7FFF;
    repeat (6) applyStimulus(1'b0, 1'b1, 30000);
    repeat (4) applyStimulus(1'b0, 1'b1, -30000);
    flush();
    exp_q = '{30000, 32767, 32767, 32767, 32767, 32767, -1, -32768, -32768, -32768};
    exp_sat_q = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1};
    checkRun("sat");

    $display("[TB] bypass with D=0");
    doReset();
    mode = 1'b0; delay_time = 14'd0; alpha = 16'sh7FFF;
    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(0, 65535)) - 32768;
      exp_q.push_back(v);
      exp_sat_q.push_back(0);
      applyStimulus(1'b0, 1'b1, v);
    end
    flush();
    checkRun("bypass");

    $display("[TB] wrap-around with gaps on 16-entry instance");
    doReset();
    mode_s = 1'b0; delay_s = 4'd15; alpha_s = 16'sh7FFF;
    for (int n = 1; n <= 40; n++) begin
      repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, n);
    end
    repeat (4) applyStimulus(1'b1, 1'b0, 0);
    checkOutput("wrap_count", out_s_q.size(), 40);
    for (int n = 1; n <= 40; n++) begin
      if (n <= out_s_q.size())
        checkOutput($sformatf("wrap_data%0d", n), out_s_q[n-1], n <= 15 ? n : 2 * n - 15);
    end

    $display("[TB] asynchronous reset mid-decay");
    doReset();
    mode = 1'b1; delay_time = 14'd4; alpha = 16'sh4000;
    applyStimulus(1'b0, 1'b1, 1000);
    repeat (5) applyStimulus(1'b0, 1'b1, 0);
    checkOutput("arst_pre_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", int'(out_valid), 0);
    checkOutput("arst_out_data", int'(out_data), 0);
    checkOutput("arst_sat", int'(sat), 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_q.delete();
    sat_q.delete();
    cyc_q.delete();
    exp_q.delete();
    exp_sat_q.delete();
    decayRun("arst");

    checkOutput("sat_when_idle", sat_idle_err, 0);
    checkOutput("hold_when_idle", hold_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/echo_delay_gen2.md
Name: echo_delay_gen2

Overview:
Parametrised successor to the single-tap echo stage in the soundboard audio chain. It sits after the LPF2 filter output and in front of the final output.
It adds a sample-valid handshake, selectable feed-forward or feedback (decaying repeat) mode, and a runtime delay of up to 2^DEPTH_LOG2-1 samples. It also provides round-half-up Q1.(GAIN_W-1) gain, output saturation with a flag, and history masking so no RAM clear is needed after reset.

Parameters:
DATA_W, 16, signed sample width
DEPTH_LOG2, 14, log2 of the delay-line depth; DEPTH = 2^DEPTH_LOG2 entries
GAIN_W, 16, signed gain width, format Q1.(GAIN_W-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input sample strobe; one sample accepted per cycle when high
in_data  in  DATA_W  signed input sample
delay_time  in  DEPTH_LOG2  echo delay D in samples; 0 means no echo
alpha  in  GAIN_W  signed echo gain, Q1.(GAIN_W-1); 0x7FFF ≈ +1.0 at the default width
mode  in  1  0 = feed-forward y[n]=x[n]+a·x[n-D]; 1 = feedback y[n]=x[n]+a·y[n-D]
out_valid  out  1  output sample strobe
out_data  out  DATA_W  signed output sample
sat  out  1  high together with out_valid when out_data was clipped

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. Reset clears the write pointer, history counter, pipeline valids, out_valid, out_data and sat to 0. RAM contents are not cleared.
- Pipeline: 2-stage pipeline. A sample accepted at cycle t produces out_valid at cycle t+2. There is no backpressure. Gaps in in_valid create matching gaps in out_valid, and delay is counted in accepted samples, not cycles.
- Stage 1 (on in_valid):
  - Latch x, D, alpha and mode.
  - Issue a synchronous RAM read at addr = (wp - D) mod DEPTH.
  - wp is the index of the current sample.
  - Increment wp; it wraps at DEPTH.
  - hist = number of samples accepted since reset, saturating at DEPTH.
- Stage 2:
  - delayed = 0 if D == 0 or hist_at_accept < D; otherwise it is the RAM read data.
  - prod = alpha·delayed, full DATA_W+GAIN_W bits signed.
  - Add 2^(GAIN_W-2), then arithmetic shift right by GAIN_W-1.
  - sum = x + scaled, computed at DATA_W+2 bits.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat = 1 when clipped.
  - Register the result into out_data.
- RAM write:
  - mode 0: write x at stage-1 addr wp.
  - mode 1: write the saturated y at the same sample's address in stage 2.
  - Exactly one write per accepted sample.
- Read-during-write hazard (mode 1, D = 1, back-to-back samples): when the stage-1 read address equals the stage-2 write address in the same cycle, forward the write data. Result must equal the ideal recurrence.
- Runtime changes: changes to D, alpha and mode apply from the next accepted sample. History is not cleared, so a mode switch mixes stored x and y values.
- out_data holds its value when out_valid = 0. sat is 0 whenever out_valid = 0.
- Reset mid-stream: all in-flight samples are dropped. After release, the first D outputs equal the input, because hist masks stale RAM contents.
- Expected size: about 150–250 lines of RTL.

Test Plan:
1. Feed-forward impulse, latency and echo position
   - Stimulus: mode 0, D=4, alpha=0x4000, in_valid held high, input 1000 then zeros.
   - Required: out_valid 2 cycles after the first sample. Outputs are 1000, 0, 0, 0, 500, then zeros; sat is never asserted.
2. Feedback decay with rounding
   - Stimulus: mode 1, D=4, alpha=0x4000, input 1000 then zeros.
   - Required: outputs at samples 0/4/8/12/16 are 1000/500/250/125/63 (round-half-up); all other samples are 0.
3. Forwarding path at minimum delay
   - Stimulus: mode 1, D=1, alpha=0x4000, back-to-back samples, input 1000 then zeros.
   - Required: outputs 1000, 500, 250, 125, 63, 32.
4. Saturation and bypass
   - Stimulus A: mode 0, D=1, alpha=0x7FFF, constant input 30000.
   - Required A: first output 30000 with sat=0; every later output 32767 with sat=1.
   - Stimulus B: D=0, random input.
   - Required B: out_data == in_data exactly and sat=0.
5. Pointer wrap-around and valid gaps
   - Stimulus: DEPTH_LOG2=4, D=15, alpha=0x7FFF, mode 0, ramp 1..40 with random in_valid gaps.
   - Required: out[n]=n for n ≤ 15 and out[n]=2n-15 for n ≥ 16, with out_valid count equal to 40.
6. Asynchronous reset mid-decay
   - Stimulus: assert rst asynchronously during scenario 2's decay, release it, then send 1000 followed by zeros.
   - Required: out_valid drops immediately. Post-reset outputs match scenario 2, with no stale echoes.
